// File: rtl/ahb_slave_arbiter.sv
// Round-robin arbiter granting one of CHANNEL_NUM AHB masters access to a single slave port.
// Tracks burst length so the grant only moves at burst boundaries and honours HMASTLOCK.
module ahb_slave_arbiter #(
    parameter int unsigned CHANNEL_NUM = 4
) (
    input  logic                       hclk,
    input  logic                       hreset,
    input  logic [CHANNEL_NUM-1:0]     hreq,
    input  logic [2*CHANNEL_NUM-1:0]   htrans,
    input  logic [3*CHANNEL_NUM-1:0]   hburst,
    input  logic [CHANNEL_NUM-1:0]     hmastlock,
    input  logic                       hready,
    output logic [CHANNEL_NUM-1:0]     addr_sel,
    output logic [CHANNEL_NUM-1:0]     data_sel,
    output logic [CHANNEL_NUM-1:0]     hready_m,
    output logic                       busy
);

    localparam int unsigned IdxW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    localparam logic [1:0] TransIdle   = 2'd0;
    localparam logic [1:0] TransNonseq = 2'd2;
    localparam logic [2:0] BurstIncr   = 3'd1;

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e                 state_q, state_d;
    logic [CHANNEL_NUM-1:0] addr_sel_q, addr_sel_d;
    logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   incr_q, incr_d;

    logic [1:0]      o_trans;
    logic [2:0]      o_burst;
    logic            o_lock;
    logic            o_req;
    logic            win_found;
    logic [IdxW-1:0] win_idx;
    logic            accepted;
    logic            done;
    logic            rearb;
    logic [4:0]      beat_cnt;
    logic            beat_incr;

    function automatic logic [4:0] burst_len(input logic [2:0] b);
        logic [4:0] len;
        unique case (b)
            3'd0:       len = 5'd1;
            3'd2, 3'd3: len = 5'd4;
            3'd4, 3'd5: len = 5'd8;
            3'd6, 3'd7: len = 5'd16;
            default:    len = 5'd0;
        endcase
        return len;
    endfunction

    // Owner's transfer controls.
    always_comb begin
        o_trans = TransIdle;
        o_burst = 3'd0;
        o_lock  = 1'b0;
        o_req   = 1'b0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (owner_q == IdxW'(i)) begin
                o_trans = htrans[2*i +: 2];
                o_burst = hburst[3*i +: 3];
                o_lock  = hmastlock[i];
                o_req   = hreq[i];
            end
        end
    end

    // Search upward from rr_ptr+1; the current owner is therefore visited last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= CHANNEL_NUM; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr_q) + k) % CHANNEL_NUM;
            if (!win_found && hreq[idx]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(idx);
            end
        end
    end

    always_comb begin
        accepted  = (state_q == StOwn) && hready && o_trans[1];
        beat_cnt  = cnt_q;
        beat_incr = incr_q;
        if (accepted) begin
            if (o_trans == TransNonseq) begin
                beat_incr = (o_burst == BurstIncr);
                beat_cnt  = beat_incr ? 5'd0 : burst_len(o_burst) - 5'd1;
            end else if (cnt_q != 5'd0) begin
                beat_cnt = cnt_q - 5'd1;
            end
        end

        done = (accepted && !beat_incr && beat_cnt == 5'd0)
            || (incr_q && (o_trans == TransIdle || o_trans == TransNonseq))
            || (!incr_q && cnt_q == 5'd0 && o_trans == TransIdle)
            || !o_req;
        rearb = (state_q == StOwn) && hready && done && !o_lock;

        state_d    = state_q;
        addr_sel_d = addr_sel_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        incr_d     = incr_q;
        data_sel_d = data_sel_q;

        if (hready) begin
            data_sel_d = accepted ? addr_sel_q : '0;
        end
        if (state_q == StOwn && hready) begin
            cnt_d  = beat_cnt;
            incr_d = beat_incr;
        end

        if ((state_q == StIdle) || rearb) begin
            if (win_found) begin
                state_d             = StOwn;
                addr_sel_d          = '0;
                addr_sel_d[win_idx] = 1'b1;
                owner_d             = win_idx;
                rr_ptr_d            = win_idx;
                if (state_q == StIdle || win_idx != owner_q) begin
                    cnt_d  = 5'd0;
                    incr_d = 1'b0;
                end
            end else begin
                state_d    = StIdle;
                addr_sel_d = '0;
                cnt_d      = 5'd0;
                incr_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= StIdle;
            addr_sel_q <= '0;
            data_sel_q <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= IdxW'(CHANNEL_NUM - 1);
            cnt_q      <= 5'd0;
            incr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_sel_q <= addr_sel_d;
            data_sel_q <= data_sel_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            incr_q     <= incr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            hready_m[i] = (addr_sel_q[i] || data_sel_q[i]) ? hready : !hreq[i];
        end
    end

    assign addr_sel = addr_sel_q;
    assign data_sel = data_sel_q;
    assign busy     = (state_q == StOwn);

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed scenarios for ahb_slave_arbiter; each cycle's hand-derived expectations are queued
// with the stimulus and checked after the following clock edge.
module tb_ahb_slave_arbiter;

    localparam int unsigned N = 4;

    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSQ = 2'd2, SEQ = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;

    logic             hclk = 1'b0;
    logic             hreset;
    logic [N-1:0]     hreq;
    logic [2*N-1:0]   htrans;
    logic [3*N-1:0]   hburst;
    logic [N-1:0]     hmastlock;
    logic             hready;
    logic [N-1:0]     addr_sel;
    logic [N-1:0]     data_sel;
    logic [N-1:0]     hready_m;
    logic             busy;

    typedef struct {
        logic [3:0] a;
        logic [3:0] d;
        logic [3:0] hm;
        logic       b;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ahb_slave_arbiter #(.CHANNEL_NUM(N)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hreq      (hreq),
        .htrans    (htrans),
        .hburst    (hburst),
        .hmastlock (hmastlock),
        .hready    (hready),
        .addr_sel  (addr_sel),
        .data_sel  (data_sel),
        .hready_m  (hready_m),
        .busy      (busy)
    );

    always #5 hclk = ~hclk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: master m drives t/b/l, all others IDLE; ea/ed are the register values after the edge.
    task automatic cyc(input logic rst, input logic [3:0] req, input int m, input logic [1:0] t,
                       input logic [2:0] b, input logic l, input logic rdy,
                       input logic [3:0] ea, input logic [3:0] ed, input string tag);
        exp_t e;
        hreset    = rst;
        hreq      = req;
        htrans    = '0;
        hburst    = '0;
        hmastlock = '0;
        htrans[2*m +: 2] = t;
        hburst[3*m +: 3] = b;
        hmastlock[m]     = l;
        hready    = rdy;
        e.a   = ea;
        e.d   = ed;
        e.b   = (ea != 4'b0000);
        e.tag = tag;
        for (int i = 0; i < 4; i++) e.hm[i] = (ea[i] | ed[i]) ? rdy : ~req[i];
        sb_q.push_back(e);
        @(posedge hclk);
        #1;
        e = sb_q.pop_front();
        check_eq({e.tag, "/addr_sel"}, 16'(addr_sel), 16'(e.a));
        check_eq({e.tag, "/data_sel"}, 16'(data_sel), 16'(e.d));
        check_eq({e.tag, "/hready_m"}, 16'(hready_m), 16'(e.hm));
        check_eq({e.tag, "/busy"}, 16'(busy), 16'(e.b));
        check_eq({e.tag, "/onehot"}, 16'($onehot0(addr_sel) && $onehot0(data_sel)), 16'd1);
    endtask

    initial begin
        // Reset and the basic two-requester handover.
        cyc(1, 4'b0101, 0, IDLE, SINGLE, 0, 1, 4'b0000, 4'b0000, "rst0");
        cyc(1, 4'b0101, 0, IDLE, SINGLE, 0, 1, 4'b0000, 4'b0000, "rst1");
        cyc(0, 4'b0101, 0, IDLE, SINGLE, 0, 1, 4'b0001, 4'b0000, "a_grant0");
        cyc(0, 4'b0101, 0, NSQ,  SINGLE, 0, 1, 4'b0100, 4'b0001, "a_switch2");
        cyc(0, 4'b0100, 2, NSQ,  SINGLE, 0, 1, 4'b0100, 4'b0100, "a_keep2");
        cyc(0, 4'b0000, 2, IDLE, SINGLE, 0, 1, 4'b0000, 4'b0000, "a_idle");

        // INCR4 on master1 with a stalled second beat; master2 waits.
        cyc(0, 4'b0110, 1, IDLE, INCR4,  0, 1, 4'b0010, 4'b0000, "b_grant1");
        cyc(0, 4'b0110, 1, NSQ,  INCR4,  0, 1, 4'b0010, 4'b0010, "b_beat1");
        cyc(0, 4'b0110, 1, SEQ,  INCR4,  0, 0, 4'b0010, 4'b0010, "b_stall1");
        cyc(0, 4'b0110, 1, SEQ,  INCR4,  0, 0, 4'b0010, 4'b0010, "b_stall2");
        cyc(0, 4'b0110, 1, SEQ,  INCR4,  0, 0, 4'b0010, 4'b0010, "b_stall3");
        cyc(0, 4'b0110, 1, SEQ,  INCR4,  0, 1, 4'b0010, 4'b0010, "b_beat2");
        cyc(0, 4'b0110, 1, SEQ,  INCR4,  0, 1, 4'b0010, 4'b0010, "b_beat3");
        cyc(0, 4'b0110, 1, SEQ,  INCR4,  0, 1, 4'b0100, 4'b0010, "b_beat4");
        cyc(0, 4'b0100, 2, NSQ,  SINGLE, 0, 1, 4'b0100, 4'b0100, "b_m2");
        cyc(0, 4'b0000, 2, IDLE, SINGLE, 0, 1, 4'b0000, 4'b0000, "b_idle");

        // Undefined-length INCR with a BUSY beat, terminated by IDLE.
        cyc(0, 4'b1000, 3, IDLE, INCR,   0, 1, 4'b1000, 4'b0000, "c_grant3");
        cyc(0, 4'b1000, 3, NSQ,  INCR,   0, 1, 4'b1000, 4'b1000, "c_nseq");
        cyc(0, 4'b1000, 3, SEQ,  INCR,   0, 1, 4'b1000, 4'b1000, "c_seq");
        cyc(0, 4'b1000, 3, BUSY, INCR,   0, 1, 4'b1000, 4'b0000, "c_busy");
        cyc(0, 4'b0000, 3, IDLE, INCR,   0, 1, 4'b0000, 4'b0000, "c_end");
        cyc(0, 4'b0000, 3, IDLE, INCR,   0, 1, 4'b0000, 4'b0000, "c_after");

        // Locked master0 keeps the grant against all requesters.
        cyc(0, 4'b1111, 0, IDLE, SINGLE, 1, 1, 4'b0001, 4'b0000, "d_grant0");
        cyc(0, 4'b1111, 0, NSQ,  SINGLE, 1, 1, 4'b0001, 4'b0001, "d_lock1");
        cyc(0, 4'b1111, 0, NSQ,  SINGLE, 1, 1, 4'b0001, 4'b0001, "d_lock2");
        cyc(0, 4'b1111, 0, IDLE, SINGLE, 0, 1, 4'b0010, 4'b0000, "d_unlock");

        // Continuous round-robin over SINGLE transfers.
        cyc(0, 4'b1111, 1, NSQ,  SINGLE, 0, 1, 4'b0100, 4'b0010, "e_rr1");
        cyc(0, 4'b1111, 2, NSQ,  SINGLE, 0, 1, 4'b1000, 4'b0100, "e_rr2");
        cyc(0, 4'b1111, 3, NSQ,  SINGLE, 0, 1, 4'b0001, 4'b1000, "e_rr3");
        cyc(0, 4'b1111, 0, NSQ,  SINGLE, 0, 1, 4'b0010, 4'b0001, "e_rr0");
        cyc(0, 4'b0000, 1, IDLE, SINGLE, 0, 1, 4'b0000, 4'b0000, "e_idle");

        // Reset during the third beat of INCR8, then lowest-index grant.
        cyc(0, 4'b0001, 0, IDLE, INCR8,  0, 1, 4'b0001, 4'b0000, "f_grant0");
        cyc(0, 4'b0001, 0, NSQ,  INCR8,  0, 1, 4'b0001, 4'b0001, "f_beat1");
        cyc(0, 4'b0001, 0, SEQ,  INCR8,  0, 1, 4'b0001, 4'b0001, "f_beat2");
        cyc(1, 4'b0001, 0, SEQ,  INCR8,  0, 1, 4'b0000, 4'b0000, "f_reset");
        cyc(0, 4'b1001, 0, IDLE, SINGLE, 0, 1, 4'b0001, 4'b0000, "f_regrant");
        cyc(0, 4'b0000, 0, IDLE, SINGLE, 0, 1, 4'b0000, 4'b0000, "f_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_slave_arbiter.md
AHB_SLAVE_ARBITER -- requirements
Module: ahb_slave_arbiter

Interface
REQ-001 SHALL have parameter CHANNEL_NUM, default 4, meaning number of masters competing for this slave port (2..16).
REQ-002 SHALL have ports in order: hclk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have hreset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have hreq  in  CHANNEL_NUM  master i drives NONSEQ/SEQ/BUSY decoded to this slave.
REQ-005 SHALL have htrans  in  CHANNEL_NUM x 2  per-master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-006 SHALL have hburst  in  CHANNEL_NUM x 3  per-master HBURST (AMBA encoding).
REQ-007 SHALL have hmastlock  in  CHANNEL_NUM  per-master HMASTLOCK.
REQ-008 SHALL have hready  in  1  HREADYOUT of the slave.
REQ-009 SHALL have addr_sel  out  CHANNEL_NUM  one-hot/zero select for the address-phase payload mux.
REQ-010 SHALL have data_sel  out  CHANNEL_NUM  one-hot/zero select for the data-phase payload mux.
REQ-011 SHALL have hready_m  out  CHANNEL_NUM  per-master HREADY.
REQ-012 SHALL have busy  out  1  high while state is OWN.

Function
REQ-013 SHALL implement states IDLE (addr_sel=0) and OWN (addr_sel = owner one-hot); addr_sel and data_sel SHALL never have more than one bit set.
REQ-014 IDLE -> OWN on the clock edge after any hreq bit is high; winner registered into addr_sel (1-cycle grant latency).
REQ-015 Winner SHALL be chosen round-robin: first requesting index searching upward from rr_ptr+1, modulo CHANNEL_NUM; rr_ptr updates to winner index at every grant.
REQ-016 Accepted beat: cycle in OWN with hready=1 and owner htrans in {NONSEQ, SEQ}.
REQ-017 On accepted NONSEQ, beat counter SHALL load: SINGLE=1, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16, INCR=unbounded flag; each accepted beat decrements by 1 (5-bit counter).
REQ-018 Burst complete: counter reaches 0 after an accepted beat, or for INCR the owner htrans is IDLE or NONSEQ at an hready=1 cycle.
REQ-019 Rearbitration SHALL occur only at an hready=1 edge with burst complete and owner hmastlock=0; BUSY beats and hready=0 cycles SHALL hold the grant and counter.
REQ-020 At rearbitration: other requesters present -> switch owner (OWN->OWN, new one-hot next cycle); only owner requesting -> keep owner; none requesting -> IDLE.
REQ-021 hmastlock=1 on owner SHALL hold the grant regardless of other hreq until an hready=1 cycle with hmastlock=0 and burst complete.
REQ-022 data_sel SHALL load addr_sel on every edge where hready=1 and a beat is accepted; SHALL clear to 0 on hready=1 edges with no accepted beat; SHALL hold when hready=0.
REQ-023 hready_m[i] = hready if addr_sel[i] or data_sel[i]; else 0 if hreq[i]; else 1 (combinational).
REQ-024 Owner dropping hreq mid-burst (protocol violation) SHALL be treated as INCR termination: rearbitrate at next hready=1 edge.
REQ-025 Simultaneous new-owner address phase and old-owner data phase SHALL be supported: addr_sel=new, data_sel=old in the same cycle.

Reset
REQ-026 While hreset=1 at an edge: state=IDLE, addr_sel=0, data_sel=0, counter=0, incr flag=0, rr_ptr=CHANNEL_NUM-1, busy=0; hready_m follows REQ-023 with those values.
REQ-027 Reset asserted mid-burst SHALL abort immediately; first grant after release SHALL go to lowest requesting index at or above 0.

Verification
REQ-028 hreq=4'b0101 from reset -> cycle 1 addr_sel=0001; after master0 SINGLE beat with hready=1, addr_sel=0100, data_sel=0001 same cycle.
REQ-029 Master1 INCR4 with master2 requesting, hready=0 on beat 2 for 3 cycles -> addr_sel=0010 for exactly 4 accepted beats + stalls, then 0100; hready_m[2]=0 throughout.
REQ-030 Master3 INCR with one BUSY beat then IDLE -> grant held through BUSY, released on IDLE edge; data_sel=0 on following cycle if no new requester.
REQ-031 Master0 hmastlock=1 over two SINGLE transfers with hreq=1111 -> addr_sel stays 0001; next owner after unlock is 0010.
REQ-032 All four requesting continuously with SINGLE transfers -> grant order 0,1,2,3,0; never two bits set in addr_sel or data_sel.
REQ-033 hreset=1 during beat 3 of INCR8 -> next edge all outputs per REQ-026, busy=0.
